// File: rtl/vga_square_animator.sv
// Per-frame motion controller for the square renderer.
// Holds position and direction for N_SQ squares. Once every FRAME_DIV vsync
// falling edges it moves each square by STEP pixels and bounces it off the
// visible-area edges. Squares are updated one per cycle during vertical sync,
// so the pixel compare logic sees stable coordinates for the whole active frame.
//
// state  | meaning
// IDLE   | waiting for an update-qualifying vsync falling edge
// UPDATE | stepping square idx this cycle
// DONE   | one-cycle frame_done pulse, then back to IDLE
module vga_square_animator #(
  parameter int N_SQ      = 4,
  parameter int X_W       = 10,
  parameter int Y_W       = 10,
  parameter int H_RES     = 640,
  parameter int V_RES     = 480,
  parameter int SIZE      = 160,
  parameter int STEP      = 2,
  parameter int FRAME_DIV = 1
) (
  input  logic                clk_in,
  input  logic                rst,
  input  logic                vsync,
  input  logic                en,
  output logic [N_SQ*X_W-1:0] sq_x,
  output logic [N_SQ*Y_W-1:0] sq_y,
  output logic                busy,
  output logic                frame_done
);

  localparam int IW    = (N_SQ > 1) ? $clog2(N_SQ) : 1;
  localparam int CW    = (FRAME_DIV > 1) ? $clog2(FRAME_DIV) : 1;
  localparam int X_LIM = H_RES - SIZE;
  localparam int Y_LIM = V_RES - SIZE;

  typedef enum logic [1:0] {IDLE, UPDATE, DONE} state_t;

  state_t          state, state_nxt;
  logic [IW-1:0]   idx, idx_nxt;
  logic            vsync_q;
  logic [CW-1:0]   frame_cnt;
  logic            fe, frame_tc, go;

  logic [X_W-1:0]  x_r [N_SQ];
  logic [Y_W-1:0]  y_r [N_SQ];
  // Direction bit: 0 = moving towards larger coordinates, 1 = towards zero.
  logic [N_SQ-1:0] dir_x, dir_y;

  logic [X_W:0]    cur_x, nxt_x;
  logic [Y_W:0]    cur_y, nxt_y;
  logic            nxt_dx, nxt_dy;

  assign fe       = vsync_q & ~vsync;
  assign frame_tc = (frame_cnt == CW'(FRAME_DIV - 1));
  // Edges arriving outside IDLE are neither acted on nor counted.
  assign go       = fe & en & (state == IDLE) & frame_tc;

  // Register vsync once for falling-edge detection.
  always_ff @(posedge clk_in or negedge rst) begin
    if (!rst) vsync_q <= 1'b1;
    else      vsync_q <= vsync;
  end

  // Frame divider: held at zero while motion is disabled.
  always_ff @(posedge clk_in or negedge rst) begin
    if (!rst)                        frame_cnt <= '0;
    else if (!en)                    frame_cnt <= '0;
    else if (fe && (state == IDLE))  frame_cnt <= frame_tc ? '0 : frame_cnt + CW'(1);
  end

  // FSM state and square index registers.
  always_ff @(posedge clk_in or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
      idx   <= '0;
    end else begin
      state <= state_nxt;
      idx   <= idx_nxt;
    end
  end

  // Next-state logic and status outputs decoded from the state register.
  always_comb begin
    state_nxt  = state;
    idx_nxt    = idx;
    busy       = 1'b0;
    frame_done = 1'b0;
    case (state)
      IDLE: begin
        if (go) begin
          state_nxt = UPDATE;
          idx_nxt   = '0;
        end
      end
      UPDATE: begin
        busy = 1'b1;
        if (idx == IW'(N_SQ - 1)) state_nxt = DONE;
        else                      idx_nxt   = idx + IW'(1);
      end
      DONE: begin
        frame_done = 1'b1;
        state_nxt  = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Bounce step for the selected square; one extra bit keeps x+STEP from wrapping.
  always_comb begin
    cur_x  = {1'b0, x_r[idx]};
    cur_y  = {1'b0, y_r[idx]};
    nxt_x  = cur_x;
    nxt_y  = cur_y;
    nxt_dx = dir_x[idx];
    nxt_dy = dir_y[idx];
    if (!dir_x[idx]) begin
      if (cur_x >= (X_W+1)'(X_LIM - STEP)) begin
        nxt_x  = (X_W+1)'(X_LIM);
        nxt_dx = 1'b1;
      end else begin
        nxt_x  = cur_x + (X_W+1)'(STEP);
      end
    end else begin
      if (cur_x <= (X_W+1)'(STEP)) begin
        nxt_x  = '0;
        nxt_dx = 1'b0;
      end else begin
        nxt_x  = cur_x - (X_W+1)'(STEP);
      end
    end
    if (!dir_y[idx]) begin
      if (cur_y >= (Y_W+1)'(Y_LIM - STEP)) begin
        nxt_y  = (Y_W+1)'(Y_LIM);
        nxt_dy = 1'b1;
      end else begin
        nxt_y  = cur_y + (Y_W+1)'(STEP);
      end
    end else begin
      if (cur_y <= (Y_W+1)'(STEP)) begin
        nxt_y  = '0;
        nxt_dy = 1'b0;
      end else begin
        nxt_y  = cur_y - (Y_W+1)'(STEP);
      end
    end
  end

  // Position/direction storage; only square idx is written, and only in UPDATE.
  always_ff @(posedge clk_in or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < N_SQ; i++) begin
        x_r[i]   <= X_W'(120 + 80 * i);
        y_r[i]   <= Y_W'(40 + 80 * i);
        dir_x[i] <= (i % 2) == 1;
        dir_y[i] <= 1'b0;
      end
    end else if (state == UPDATE) begin
      x_r[idx]   <= nxt_x[X_W-1:0];
      y_r[idx]   <= nxt_y[Y_W-1:0];
      dir_x[idx] <= nxt_dx;
      dir_y[idx] <= nxt_dy;
    end
  end

  // Flatten the coordinate arrays onto the output buses.
  always_comb begin
    sq_x = '0;
    sq_y = '0;
    for (int i = 0; i < N_SQ; i++) begin
      sq_x[i*X_W +: X_W] = x_r[i];
      sq_y[i*Y_W +: Y_W] = y_r[i];
    end
  end

endmodule

// File: tb/tb_vga_square_animator.sv
// Bench for vga_square_animator: expected coordinates are queued as each
// vsync pulse is issued; a monitor compares them on every frame_done.
module tb_vga_square_animator;

  logic        clk_in = 1'b0;
  logic        rst    = 1'b0;
  logic        vsync  = 1'b1;
  logic        vsync2 = 1'b1;
  logic        en     = 1'b1;
  logic [39:0] sq_x, sq_y, sq_x2, sq_y2;
  logic        busy, frame_done, busy2, frame_done2;

  int compared   = 0;
  int mismatched = 0;

  typedef struct {
    logic [39:0] ex, mx, ey, my;
  } exp_t;
  exp_t q[$];

  int busy_run    = 0;
  int busy_total  = 0;
  int busy2_total = 0;
  int fd2_total   = 0;

  always #5 clk_in = ~clk_in;

  vga_square_animator dut (
    .clk_in(clk_in), .rst(rst), .vsync(vsync), .en(en),
    .sq_x(sq_x), .sq_y(sq_y), .busy(busy), .frame_done(frame_done)
  );

  vga_square_animator #(.FRAME_DIV(3)) dut3 (
    .clk_in(clk_in), .rst(rst), .vsync(vsync2), .en(en),
    .sq_x(sq_x2), .sq_y(sq_y2), .busy(busy2), .frame_done(frame_done2)
  );

  function automatic logic [39:0] pk(int a3, int a2, int a1, int a0);
    return {10'(a3), 10'(a2), 10'(a1), 10'(a0)};
  endfunction

  function automatic logic [39:0] fm(int i);
    return 40'h3FF << (10 * i);
  endfunction

  function automatic logic [39:0] fv(int i, int v);
    return 40'(v) << (10 * i);
  endfunction

  task automatic chk(input string name, input logic [39:0] act, input logic [39:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  // Scoreboard monitor: busy run length and coordinates at each frame_done.
  always @(negedge clk_in) begin
    if (!rst) begin
      busy_run = 0;
    end else begin
      if (busy) begin
        busy_run++;
        busy_total++;
      end
      if (busy2) busy2_total++;
      if (frame_done2) fd2_total++;
      if (frame_done) begin
        chk("busy_len", 40'(busy_run), 40'd4);
        busy_run = 0;
        if (q.size() == 0) begin
          chk("unexpected_frame_done", 40'd1, 40'd0);
        end else begin
          exp_t e;
          e = q.pop_front();
          if (e.mx != '0) chk("sb_x", sq_x & e.mx, e.ex & e.mx);
          if (e.my != '0) chk("sb_y", sq_y & e.my, e.ey & e.my);
        end
      end
    end
  end

  task automatic pulse(input bit push, input exp_t e);
    @(posedge clk_in); #1;
    vsync = 1'b0;
    if (push) q.push_back(e);
    @(posedge clk_in); #1;
    vsync = 1'b1;
    repeat (8) @(posedge clk_in);
  endtask

  task automatic pulse3();
    @(posedge clk_in); #1 vsync2 = 1'b0;
    @(posedge clk_in); #1 vsync2 = 1'b1;
    repeat (8) @(posedge clk_in);
  endtask

  task automatic do_reset();
    @(posedge clk_in); #1 rst = 1'b0;
    repeat (2) @(posedge clk_in);
    #1 rst = 1'b1;
    @(posedge clk_in);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    exp_t c2, e;
    int b0, f0;
    c2.ex = pk(358, 282, 198, 122); c2.mx = '1;
    c2.ey = pk(282, 202, 122, 42);  c2.my = '1;

    // 1: reset state
    repeat (3) @(posedge clk_in);
    #1 rst = 1'b1;
    @(negedge clk_in);
    chk("rst_x", sq_x, pk(360, 280, 200, 120));
    chk("rst_y", sq_y, pk(280, 200, 120, 40));
    chk("rst_busy", 40'(busy), 40'd0);
    chk("rst_done", 40'(frame_done), 40'd0);

    // 2: first update
    pulse(1'b1, c2);

    // 3: frames 2..101, bounce points on y3 and x1
    for (int f = 2; f <= 101; f++) begin
      e.ex = '0; e.mx = '0; e.ey = '0; e.my = '0;
      if (f == 20)  begin e.ey = fv(3, 320); e.my = fm(3); end
      if (f == 21)  begin e.ey = fv(3, 318); e.my = fm(3); end
      if (f == 100) begin e.ex = fv(1, 0);   e.mx = fm(1); end
      if (f == 101) begin e.ex = fv(1, 2);   e.mx = fm(1); end
      pulse(1'b1, e);
    end

    // 4: FRAME_DIV=3 instance, updates only on pulses 3 and 6
    do_reset();
    b0 = busy2_total;
    f0 = fd2_total;
    pulse3(); pulse3();
    chk("div3_busy_p2", 40'(busy2_total - b0), 40'd0);
    chk("div3_x0_p2", 40'(sq_x2[9:0]), 40'd120);
    pulse3();
    chk("div3_x0_p3", 40'(sq_x2[9:0]), 40'd122);
    pulse3(); pulse3();
    chk("div3_x0_p5", 40'(sq_x2[9:0]), 40'd122);
    pulse3();
    chk("div3_x0_p6", 40'(sq_x2[9:0]), 40'd124);
    chk("div3_done_cnt", 40'(fd2_total - f0), 40'd2);
    chk("div3_busy_cnt", 40'(busy2_total - b0), 40'd8);

    // 5: en=0 freezes motion
    do_reset();
    en = 1'b0;
    b0 = busy_total;
    e.ex = '0; e.mx = '0; e.ey = '0; e.my = '0;
    for (int f = 0; f < 5; f++) pulse(1'b0, e);
    chk("en0_busy", 40'(busy_total - b0), 40'd0);
    chk("en0_x", sq_x, pk(360, 280, 200, 120));
    en = 1'b1;
    pulse(1'b1, c2);

    // 6: reset during cycle k+2 of an update aborts it
    @(posedge clk_in); #1 vsync = 1'b0;
    @(posedge clk_in); #1 vsync = 1'b1;
    @(posedge clk_in); #1 rst = 1'b0;
    @(negedge clk_in);
    chk("abort_x", sq_x, pk(360, 280, 200, 120));
    chk("abort_y", sq_y, pk(280, 200, 120, 40));
    chk("abort_busy", 40'(busy), 40'd0);
    repeat (2) @(posedge clk_in);
    #1 rst = 1'b1;
    repeat (6) @(posedge clk_in);
    pulse(1'b1, c2);

    repeat (4) @(posedge clk_in);
    chk("queue_empty", 40'(q.size()), 40'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
